// File: rtl/i2c_xfer_sequencer_pkg.sv
// Shared constants, types and phase tables for the I2C transfer sequencer.
package i2c_xfer_sequencer_pkg;

  localparam logic [2:0] ADR_PRERLO = 3'd0;
  localparam logic [2:0] ADR_PRERHI = 3'd1;
  localparam logic [2:0] ADR_CTR    = 3'd2;
  localparam logic [2:0] ADR_TXR    = 3'd3;
  localparam logic [2:0] ADR_RXR    = 3'd3;
  localparam logic [2:0] ADR_CR     = 3'd4;
  localparam logic [2:0] ADR_SR     = 3'd4;

  localparam int SR_TIP   = 1;
  localparam int SR_AL    = 5;
  localparam int SR_BUSY  = 6;
  localparam int SR_RXACK = 7;

  localparam int CR_STA = 7;
  localparam int CR_STO = 6;
  localparam int CR_RD  = 5;
  localparam int CR_WR  = 4;
  localparam int CR_ACK = 3;
  localparam int CTR_EN = 7;

  localparam logic [7:0] CMD_START_WR     = 8'h90;
  localparam logic [7:0] CMD_WR           = 8'h10;
  localparam logic [7:0] CMD_WR_STOP      = 8'h50;
  localparam logic [7:0] CMD_RD_NACK_STOP = 8'h68;
  localparam logic [7:0] CMD_STOP         = 8'h40;
  localparam logic [7:0] CTR_ENABLE       = 8'h80;
  localparam logic [7:0] CTR_DISABLE      = 8'h00;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_NACK     = 2'd1,
    ERR_ARB_LOST = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_e;

  typedef enum logic [3:0] {
    ST_INIT, ST_IDLE, ST_LD_TXR, ST_LD_CR, ST_POLL, ST_CHECK,
    ST_RD_RXR, ST_STOP_CR, ST_STOP_POLL, ST_DIS, ST_RESP
  } state_e;

  function automatic logic [7:0] phase_cr(input logic rw, input logic [1:0] phase);
    case (phase)
      2'd0:    return CMD_START_WR;
      2'd1:    return CMD_WR;
      2'd2:    return rw ? CMD_START_WR : CMD_WR_STOP;
      default: return CMD_RD_NACK_STOP;
    endcase
  endfunction

  function automatic logic [7:0] phase_txr(input logic rw, input logic [1:0] phase,
                                           input logic [6:0] dev, input logic [7:0] reg_idx,
                                           input logic [7:0] wdata);
    case (phase)
      2'd0:    return {dev, 1'b0};
      2'd1:    return reg_idx;
      2'd2:    return rw ? {dev, 1'b1} : wdata;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic last_phase(input logic rw, input logic [1:0] phase);
    return phase == (rw ? 2'd3 : 2'd2);
  endfunction

endpackage

// File: rtl/i2c_xfer_sequencer_if.sv
// Request/response handshake and Wishbone master bus of the sequencer.
interface i2c_xfer_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [2:0] wbm_adr_o;
  logic [7:0] wbm_dat_o;
  logic [7:0] wbm_dat_i;
  logic       wbm_we_o;
  logic       wbm_stb_o;
  logic       wbm_cyc_o;
  logic       wbm_ack_i;

  modport master (
    input  req_valid, req_rw, req_dev, req_reg, req_wdata, wbm_dat_i, wbm_ack_i,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o
  );

  modport slave (
    output req_valid, req_rw, req_dev, req_reg, req_wdata, wbm_dat_i, wbm_ack_i,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o
  );
endinterface

// File: rtl/i2c_xfer_sequencer_wbm_access.sv
// Single Wishbone read/write engine; done_o pulses the cycle after ack with rdata_o captured.
module i2c_xfer_sequencer_wbm_access (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       start_i,
  input  logic       we_i,
  input  logic [2:0] adr_i,
  input  logic [7:0] dat_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);
  logic       stb_q, we_q, done_q;
  logic [2:0] adr_q;
  logic [7:0] dat_q, rdata_q;

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 3'd0;
      dat_q   <= 8'h00;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      done_q <= 1'b0;
      if (stb_q) begin
        if (wb_ack_i) begin
          stb_q   <= 1'b0;
          we_q    <= 1'b0;
          adr_q   <= 3'd0;
          dat_q   <= 8'h00;
          done_q  <= 1'b1;
          rdata_q <= wb_dat_i;
        end
      end else if (start_i) begin
        stb_q <= 1'b1;
        we_q  <= we_i;
        adr_q <= adr_i;
        dat_q <= dat_i;
      end
    end
  end

  assign done_o   = done_q;
  assign rdata_o  = rdata_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_we_o  = we_q;
  assign wb_stb_o = stb_q;
endmodule

// File: rtl/i2c_xfer_sequencer.sv
// Sequences PRER/CTR/TXR/CR/SR accesses of a byte-level I2C core into full register writes/reads.
// state      | meaning
// INIT       | program prescaler and enable core (step 0..2)
// IDLE       | req_ready=1, wait for request
// LD_TXR     | write phase byte to TXR
// LD_CR      | write phase command to CR
// POLL       | read SR until TIP clears
// CHECK      | evaluate AL / RxACK, pick next phase
// RD_RXR     | fetch received byte
// STOP_CR    | issue STO after NACK
// STOP_POLL  | read SR until Busy clears
// DIS        | disable/re-enable core after timeout (step 0..1)
// RESP       | publish result
module i2c_xfer_sequencer
  import i2c_xfer_sequencer_pkg::*;
#(
  parameter logic [15:0] PRESCALE      = 16'd99,
  parameter int          TIMEOUT_POLLS = 4096
) (
  input logic wb_clk_i,
  input logic arst_i,
  i2c_xfer_sequencer_if.master bus_io
);
  localparam int CNT_W = $clog2(TIMEOUT_POLLS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_POLLS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_POLLS);

  state_e           state_q;
  logic [1:0]       phase_q, step_q;
  logic             rw_q;
  logic [6:0]       dev_q;
  logic [7:0]       reg_q, wdata_q, rdata_q;
  err_e             err_q, rsp_err_q;
  logic [CNT_W-1:0] poll_cnt_q;
  logic             sr_al_q, sr_rxack_q;
  logic             req_ready_q, rsp_valid_q;
  logic [7:0]       rsp_rdata_q;
  logic             acc_start_q, acc_pend_q, acc_we_q;
  logic [2:0]       acc_adr_q;
  logic [7:0]       acc_dat_q;
  logic             acc_we_d, acc_state;
  logic [2:0]       acc_adr_d;
  logic [7:0]       acc_dat_d;
  logic             acc_done;
  logic [7:0]       acc_rdata;
  logic             poll_expired;

  assign poll_expired = poll_cnt_q >= CNT_LAST;

  always_comb begin
    acc_state = 1'b1;
    acc_we_d  = 1'b1;
    acc_adr_d = ADR_CR;
    acc_dat_d = 8'h00;
    case (state_q)
      ST_INIT: begin
        acc_adr_d = {1'b0, step_q};
        acc_dat_d = (step_q == 2'd0) ? PRESCALE[7:0] :
                    (step_q == 2'd1) ? PRESCALE[15:8] : CTR_ENABLE;
      end
      ST_LD_TXR: begin
        acc_adr_d = ADR_TXR;
        acc_dat_d = phase_txr(rw_q, phase_q, dev_q, reg_q, wdata_q);
      end
      ST_LD_CR:                acc_dat_d = phase_cr(rw_q, phase_q);
      ST_POLL, ST_STOP_POLL: begin
        acc_we_d  = 1'b0;
        acc_adr_d = ADR_SR;
      end
      ST_RD_RXR: begin
        acc_we_d  = 1'b0;
        acc_adr_d = ADR_RXR;
      end
      ST_STOP_CR:              acc_dat_d = CMD_STOP;
      ST_DIS: begin
        acc_adr_d = ADR_CTR;
        acc_dat_d = (step_q == 2'd0) ? CTR_DISABLE : CTR_ENABLE;
      end
      default:                 acc_state = 1'b0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q     <= ST_INIT;
      phase_q     <= 2'd0;
      step_q      <= 2'd0;
      rw_q        <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      err_q       <= ERR_OK;
      rsp_err_q   <= ERR_OK;
      poll_cnt_q  <= '0;
      sr_al_q     <= 1'b0;
      sr_rxack_q  <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      acc_start_q <= 1'b0;
      acc_pend_q  <= 1'b0;
      acc_we_q    <= 1'b0;
      acc_adr_q   <= 3'd0;
      acc_dat_q   <= 8'h00;
    end else begin
      acc_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      // Every bus-touching state launches exactly one access on entry and waits for done.
      if (acc_state && !acc_pend_q) begin
        acc_start_q <= 1'b1;
        acc_pend_q  <= 1'b1;
        acc_we_q    <= acc_we_d;
        acc_adr_q   <= acc_adr_d;
        acc_dat_q   <= acc_dat_d;
      end
      if (acc_done) acc_pend_q <= 1'b0;

      case (state_q)
        ST_INIT: if (acc_done) begin
          if (step_q == 2'd2) begin
            step_q      <= 2'd0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            step_q <= step_q + 2'd1;
          end
        end
        ST_IDLE: if (bus_io.req_valid && req_ready_q) begin
          rw_q        <= bus_io.req_rw;
          dev_q       <= bus_io.req_dev;
          reg_q       <= bus_io.req_reg;
          wdata_q     <= bus_io.req_wdata;
          rdata_q     <= 8'h00;
          err_q       <= ERR_OK;
          phase_q     <= 2'd0;
          poll_cnt_q  <= '0;
          req_ready_q <= 1'b0;
          state_q     <= ST_LD_TXR;
        end
        ST_LD_TXR:  if (acc_done) state_q <= ST_LD_CR;
        ST_LD_CR:   if (acc_done) state_q <= ST_POLL;
        ST_STOP_CR: if (acc_done) state_q <= ST_STOP_POLL;
        ST_POLL, ST_STOP_POLL: if (acc_done) begin
          if (poll_cnt_q != CNT_MAX) poll_cnt_q <= poll_cnt_q + 1'b1;
          if (state_q == ST_POLL && !acc_rdata[SR_TIP]) begin
            sr_al_q    <= acc_rdata[SR_AL];
            sr_rxack_q <= acc_rdata[SR_RXACK];
            state_q    <= ST_CHECK;
          end else if (state_q == ST_STOP_POLL && !acc_rdata[SR_BUSY]) begin
            state_q <= ST_RESP;
          end else if (poll_expired) begin
            err_q   <= ERR_TIMEOUT;
            step_q  <= 2'd0;
            state_q <= ST_DIS;
          end
        end
        ST_CHECK: begin
          if (sr_al_q) begin
            err_q   <= ERR_ARB_LOST;
            state_q <= ST_RESP;
          end else if (sr_rxack_q && !(rw_q && phase_q == 2'd3)) begin
            err_q   <= ERR_NACK;
            state_q <= ST_STOP_CR;
          end else if (last_phase(rw_q, phase_q)) begin
            state_q <= rw_q ? ST_RD_RXR : ST_RESP;
          end else begin
            phase_q <= phase_q + 2'd1;
            // The final read phase only issues a command; there is no byte to load.
            state_q <= (rw_q && phase_q == 2'd2) ? ST_LD_CR : ST_LD_TXR;
          end
        end
        ST_RD_RXR: if (acc_done) begin
          rdata_q <= acc_rdata;
          state_q <= ST_RESP;
        end
        ST_DIS: if (acc_done) begin
          if (step_q == 2'd1) begin
            step_q  <= 2'd0;
            state_q <= ST_RESP;
          end else begin
            step_q <= 2'd1;
          end
        end
        ST_RESP: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
          rsp_rdata_q <= rdata_q;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  i2c_xfer_sequencer_wbm_access u_wbm_access (
    .wb_clk_i (wb_clk_i),
    .arst_i   (arst_i),
    .start_i  (acc_start_q),
    .we_i     (acc_we_q),
    .adr_i    (acc_adr_q),
    .dat_i    (acc_dat_q),
    .done_o   (acc_done),
    .rdata_o  (acc_rdata),
    .wb_adr_o (bus_io.wbm_adr_o),
    .wb_dat_o (bus_io.wbm_dat_o),
    .wb_we_o  (bus_io.wbm_we_o),
    .wb_stb_o (bus_io.wbm_stb_o),
    .wb_dat_i (bus_io.wbm_dat_i),
    .wb_ack_i (bus_io.wbm_ack_i)
  );

  assign bus_io.wbm_cyc_o = bus_io.wbm_stb_o;
  assign bus_io.req_ready = req_ready_q;
  assign bus_io.rsp_valid = rsp_valid_q;
  assign bus_io.rsp_rdata = rsp_rdata_q;
  assign bus_io.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Scoreboard bench: behavioural I2C core register model, expected WB writes and responses queued by stimulus.
module tb_i2c_xfer_sequencer;
  logic wb_clk_i = 1'b0;
  logic arst_i   = 1'b0;

  i2c_xfer_sequencer_if bus();

  i2c_xfer_sequencer #(.PRESCALE(16'd99), .TIMEOUT_POLLS(16)) dut (
    .wb_clk_i (wb_clk_i),
    .arst_i   (arst_i),
    .bus_io   (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0, failures = 0;
  int sr_total = 0, rsp_total = 0, accept_total = 0;
  logic [10:0] exp_wr[$];
  logic [10:0] exp_rsp[$];
  string       chk_name[$];
  logic [31:0] chk_act[$], chk_exp[$];

  int         nack_byte = -1, al_byte = -1;
  bit         stretch = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  logic       ack_q = 1'b0, rxack = 1'b0, al = 1'b0;
  logic [7:0] rd_q = 8'h00, last_txr = 8'h00;
  int         tip_left = 0, busy_left = 0;

  assign bus.wbm_ack_i = ack_q;
  assign bus.wbm_dat_i = rd_q;

  // Core register model: one-cycle registered ack, TIP busy for two SR reads per command.
  always @(posedge wb_clk_i) begin
    if (!arst_i) begin
      ack_q <= 1'b0; tip_left <= 0; busy_left <= 0; rxack <= 1'b0; al <= 1'b0;
    end else if (bus.wbm_stb_o && !ack_q) begin
      ack_q <= 1'b1;
      if (bus.wbm_we_o) begin
        if (bus.wbm_adr_o == 3'd3) last_txr <= bus.wbm_dat_o;
        if (bus.wbm_adr_o == 3'd4) begin
          if (bus.wbm_dat_o[7] || bus.wbm_dat_o[5] || bus.wbm_dat_o[4]) begin
            tip_left <= 2;
            al       <= (int'(last_txr) == al_byte);
            rxack    <= bus.wbm_dat_o[5] || (int'(last_txr) == nack_byte) || (int'(last_txr) == al_byte);
          end else if (bus.wbm_dat_o[6]) begin
            busy_left <= 2;
          end
        end
      end else if (bus.wbm_adr_o == 3'd4) begin
        rd_q <= {rxack, busy_left != 0, al, 3'b000, stretch || tip_left != 0, 1'b0};
        if (tip_left != 0) tip_left <= tip_left - 1;
        else if (busy_left != 0) busy_left <= busy_left - 1;
      end else begin
        rd_q <= rx_byte;
      end
    end else begin
      ack_q <= 1'b0;
    end
  end

  always @(posedge wb_clk_i)
    if (arst_i && bus.req_valid && bus.req_ready) accept_total++;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge wb_clk_i) begin
    while (chk_name.size() != 0) cmp(chk_name.pop_front(), chk_act.pop_front(), chk_exp.pop_front());
    if (arst_i && bus.wbm_stb_o && ack_q) begin
      cmp("wb_cyc_eq_stb", {31'd0, bus.wbm_cyc_o}, 32'd1);
      if (bus.wbm_we_o) begin
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_wb_write actual=adr%0d/0x%0h required=none", bus.wbm_adr_o, bus.wbm_dat_o);
        end else begin
          cmp("wb_write", {21'd0, bus.wbm_adr_o, bus.wbm_dat_o}, {21'd0, exp_wr.pop_front()});
        end
      end else if (bus.wbm_adr_o == 3'd4) begin
        sr_total++;
      end
    end
    if (bus.rsp_valid) begin
      rsp_total++;
      if (exp_rsp.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rsp actual=err%0d required=none", bus.rsp_err);
      end else begin
        logic [10:0] e;
        e = exp_rsp.pop_front();
        cmp("rsp_err", {30'd0, bus.rsp_err}, {30'd0, e[9:8]});
        if (e[10]) cmp("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic post(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_name.push_back(name); chk_act.push_back(act); chk_exp.push_back(exp);
  endtask

  task automatic ew(input logic [2:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
  endtask

  task automatic er(input bit chk, input logic [1:0] err, input logic [7:0] rd);
    exp_rsp.push_back({chk, err, rd});
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.req_ready && n < 2000) begin @(negedge wb_clk_i); n++; end
    post(name, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge wb_clk_i); n++;
      seen = bus.rsp_valid;
    end
    post(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic issue(input bit rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    wait_ready("ready_before_req");
    bus.req_rw = rw; bus.req_dev = dev; bus.req_reg = rg; bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    @(posedge wb_clk_i); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drained(input string name);
    @(negedge wb_clk_i);
    post(name, exp_wr.size(), 32'd0);
  endtask

  task automatic exp_write_cmd(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    ew(3'd3, {dev, 1'b0}); ew(3'd4, 8'h90);
    ew(3'd3, rg);          ew(3'd4, 8'h10);
    ew(3'd3, wd);          ew(3'd4, 8'h50);
  endtask

  initial begin
    int s0, r0, a0, n;
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_dev = 7'd0; bus.req_reg = 8'h00; bus.req_wdata = 8'h00;
    repeat (3) @(negedge wb_clk_i);
    post("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    post("rst_stb", {31'd0, bus.wbm_stb_o}, 32'd0);
    post("rst_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
    post("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    post("rst_rsp_err", {30'd0, bus.rsp_err}, 32'd0);

    // Init programming
    ew(3'd0, 8'h63); ew(3'd1, 8'h00); ew(3'd2, 8'h80);
    arst_i = 1'b1;
    wait_ready("init_ready");
    drained("init_writes_drained");

    // Plain write
    exp_write_cmd(7'h50, 8'h12, 8'hA5); er(1'b0, 2'd0, 8'h00);
    issue(1'b0, 7'h50, 8'h12, 8'hA5);
    wait_rsp("wr_rsp_seen"); drained("wr_drained");

    // Read with repeated start; RxACK set on the final read phase must be ignored
    rx_byte = 8'h3C;
    ew(3'd3, 8'hA0); ew(3'd4, 8'h90); ew(3'd3, 8'h12); ew(3'd4, 8'h10);
    ew(3'd3, 8'hA1); ew(3'd4, 8'h90); ew(3'd4, 8'h68);
    er(1'b1, 2'd0, 8'h3C);
    issue(1'b1, 7'h50, 8'h12, 8'h00);
    wait_rsp("rd_rsp_seen"); drained("rd_drained");
    repeat (4) @(negedge wb_clk_i);
    post("rsp_rdata_hold", {24'd0, bus.rsp_rdata}, 32'h3C);

    // Absent device: address NACK, explicit stop
    nack_byte = 8'h42;
    ew(3'd3, 8'h42); ew(3'd4, 8'h90); ew(3'd4, 8'h40); er(1'b0, 2'd1, 8'h00);
    issue(1'b0, 7'h21, 8'h12, 8'hA5);
    wait_rsp("nack_rsp_seen"); drained("nack_drained");
    nack_byte = -1;
    repeat (3) @(negedge wb_clk_i);
    post("rsp_err_hold", {30'd0, bus.rsp_err}, 32'd1);

    // Arbitration lost on address byte, then a normal write
    al_byte = 8'hA0;
    ew(3'd3, 8'hA0); ew(3'd4, 8'h90); er(1'b0, 2'd2, 8'h00);
    issue(1'b0, 7'h50, 8'h12, 8'hA5);
    wait_rsp("al_rsp_seen"); drained("al_drained");
    al_byte = -1;
    exp_write_cmd(7'h50, 8'h34, 8'h5A); er(1'b0, 2'd0, 8'h00);
    issue(1'b0, 7'h50, 8'h34, 8'h5A);
    wait_rsp("after_al_rsp_seen"); drained("after_al_drained");

    // Stretched SCL: timeout after exactly 16 SR reads
    stretch = 1'b1;
    s0 = sr_total;
    ew(3'd3, 8'hA0); ew(3'd4, 8'h90); ew(3'd2, 8'h00); ew(3'd2, 8'h80); er(1'b0, 2'd3, 8'h00);
    issue(1'b0, 7'h50, 8'h12, 8'hA5);
    wait_rsp("to_rsp_seen"); drained("to_drained");
    post("to_sr_reads", sr_total - s0, 32'd16);

    // Reset in the middle of a poll
    s0 = sr_total; r0 = rsp_total;
    ew(3'd3, 8'hA0); ew(3'd4, 8'h90);
    issue(1'b0, 7'h50, 8'h12, 8'hA5);
    n = 0;
    while (!((sr_total - s0) >= 3 && bus.wbm_stb_o) && n < 2000) begin @(negedge wb_clk_i); n++; end
    post("midrst_in_poll", {31'd0, bus.wbm_stb_o}, 32'd1);
    arst_i = 1'b0;
    #1;
    post("midrst_cyc_low", {31'd0, bus.wbm_cyc_o}, 32'd0);
    post("midrst_stb_low", {31'd0, bus.wbm_stb_o}, 32'd0);
    stretch = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    post("midrst_pending_drained", exp_wr.size(), 32'd0);
    ew(3'd0, 8'h63); ew(3'd1, 8'h00); ew(3'd2, 8'h80);
    arst_i = 1'b1;
    wait_ready("midrst_reinit_ready");
    drained("midrst_reinit_drained");
    post("midrst_no_rsp", rsp_total - r0, 32'd0);

    // req_valid held through a busy command
    a0 = accept_total;
    exp_write_cmd(7'h50, 8'h01, 8'h77); er(1'b0, 2'd0, 8'h00);
    wait_ready("hold_ready");
    bus.req_rw = 1'b0; bus.req_dev = 7'h50; bus.req_reg = 8'h01; bus.req_wdata = 8'h77;
    bus.req_valid = 1'b1;
    @(posedge wb_clk_i); #1;
    repeat (5) @(negedge wb_clk_i);
    post("busy_ready_low", {31'd0, bus.req_ready}, 32'd0);
    wait_rsp("hold_rsp_seen");
    bus.req_valid = 1'b0;
    drained("hold_drained");
    repeat (3) @(negedge wb_clk_i);
    post("hold_accepts", accept_total - a0, 32'd1);

    repeat (3) @(negedge wb_clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
